// File: rtl/fsk_jietiao.sv
// 2FSK demodulator: hysteresis comparator, per-window rising-crossing count, threshold decision, symbol clock.
// Optional build macro FSK_DEGLITCH_EN: comparator needs the raw condition on 2 consecutive samples.
module fsk_jietiao #(
  parameter int SYM_LEN = 2048,
  parameter int MID     = 1024,
  parameter int HYST    = 16,
  parameter int THRESH  = 24,
  parameter int POL     = 1,
  parameter int DATA_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] din,
  output logic              code_out,
  output logic              code_valid,
  output logic              code_weak,
  output logic              clk1
);

  localparam int          CW    = $clog2(SYM_LEN);
  localparam logic [11:0] TH_HI = 12'(MID + HYST);
  localparam logic [11:0] TH_LO = (MID >= HYST) ? 12'(MID - HYST) : 12'd0;
  localparam logic        POL_B = 1'(POL);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    if (inc && (v != {CW{1'b1}})) return v + CW'(1);
    return v;
  endfunction

  function automatic logic is_weak(input logic [CW-1:0] t);
    return (int'(t) >= THRESH - 1) && (int'(t) <= THRESH + 1);
  endfunction

  logic [11:0]   din_x;
  logic          raw_set, raw_clr, set_ok, clr_ok;
  logic          cmp_p0, cmp_p1;
  logic          x_p1;
  logic [CW-1:0] scnt, xcnt, tot;
  logic          hi;

  assign din_x   = 12'(din);
  assign raw_set = (din_x >= TH_HI);
  assign raw_clr = (din_x <= TH_LO);

`ifdef FSK_DEGLITCH_EN
  logic set_d, clr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      set_d <= 1'b0;
      clr_d <= 1'b0;
    end else begin
      set_d <= raw_set;
      clr_d <= raw_clr;
    end
  end

  assign set_ok = raw_set & set_d;
  assign clr_ok = raw_clr & clr_d;
`else
  assign set_ok = raw_set;
  assign clr_ok = raw_clr;
`endif

  // stage 0: comparator state (cmp_p0) and its one-cycle delay (cmp_p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_p0 <= 1'b0;
      cmp_p1 <= 1'b0;
    end else begin
      if (set_ok)      cmp_p0 <= 1'b1;
      else if (clr_ok) cmp_p0 <= 1'b0;
      cmp_p1 <= cmp_p0;
    end
  end

  // crossing in the window-end cycle still belongs to the ending window
  assign x_p1 = cmp_p0 & ~cmp_p1 & enable;
  assign tot  = sat_inc(xcnt, x_p1);
  assign hi   = (int'(tot) >= THRESH);

  // stage 1: window counters, decision and symbol clock
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt       <= '0;
      xcnt       <= '0;
      clk1       <= 1'b0;
      code_out   <= 1'b0;
      code_valid <= 1'b0;
      code_weak  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (enable) begin
        scnt <= scnt + CW'(1);
        clk1 <= (int'(scnt) >= SYM_LEN / 2);
        if (scnt == {CW{1'b1}}) begin
          code_out   <= hi ^ ~POL_B;
          code_weak  <= is_weak(tot);
          code_valid <= 1'b1;
          xcnt       <= '0;
        end else begin
          xcnt <= tot;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsk_jietiao.sv
// Self-checking bench for fsk_jietiao: POL=1 and POL=0 instances against a window-level reference model.
module tb_fsk_jietiao;

  localparam int SYM_LEN = 2048;
  localparam int MID     = 1024;
  localparam int HYST    = 16;
  localparam int THRESH  = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] din = 11'd1024;
  logic        code_out, code_valid, code_weak, clk1;
  logic        code_out_b, code_valid_b, code_weak_b, clk1_b;

  fsk_jietiao #(.SYM_LEN(SYM_LEN), .MID(MID), .HYST(HYST), .THRESH(THRESH), .POL(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .din(din),
    .code_out(code_out), .code_valid(code_valid), .code_weak(code_weak), .clk1(clk1));

  fsk_jietiao #(.SYM_LEN(SYM_LEN), .MID(MID), .HYST(HYST), .THRESH(THRESH), .POL(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .din(din),
    .code_out(code_out_b), .code_valid(code_valid_b), .code_weak(code_weak_b), .clk1(clk1_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: tone state by hysteresis rule, crossings tallied per window of enabled cycles
  logic mc1 = 1'b0, mc2 = 1'b0;
`ifdef FSK_DEGLITCH_EN
  logic ms_d = 1'b0, mcl_d = 1'b0;
`endif
  int   mpos = 0, mcnt = 0, mtot = 0;
  logic m_code = 1'b0, m_code_b = 1'b0, m_valid = 1'b0, m_weak = 1'b0, m_clk1 = 1'b0;

  logic [7:0] obs, exp_v;
  assign obs   = {code_out, code_valid, code_weak, clk1, code_out_b, code_valid_b, code_weak_b, clk1_b};
  assign exp_v = {m_code, m_valid, m_weak, m_clk1, m_code_b, m_valid, m_weak, m_clk1};

  task automatic step(input logic r, input logic e, input logic [10:0] d);
    logic x, is_hi, is_lo, set, clr;
    @(negedge clk);
    rst = r; enable = e; din = d;
    @(posedge clk);
    if (r) begin
      mc1 = 0; mc2 = 0; mpos = 0; mcnt = 0;
      m_code = 0; m_code_b = 0; m_valid = 0; m_weak = 0; m_clk1 = 0;
`ifdef FSK_DEGLITCH_EN
      ms_d = 0; mcl_d = 0;
`endif
    end else begin
      x = mc1 & ~mc2;
      m_valid = 0;
      if (e) begin
        mcnt += int'(x);
        if (mpos == SYM_LEN - 1) begin
          mtot     = (mcnt > SYM_LEN - 1) ? SYM_LEN - 1 : mcnt;
          m_code   = (mtot >= THRESH);
          m_code_b = !(mtot >= THRESH);
          m_weak   = ((mtot - THRESH) >= -1) && ((mtot - THRESH) <= 1);
          m_valid  = 1;
          mcnt     = 0;
        end
        m_clk1 = (mpos >= SYM_LEN / 2);
        mpos   = (mpos + 1) % SYM_LEN;
      end
      is_hi = (int'(d) >= MID + HYST);
      is_lo = (int'(d) <= MID - HYST);
`ifdef FSK_DEGLITCH_EN
      set = is_hi && ms_d;
      clr = is_lo && mcl_d;
      ms_d = is_hi; mcl_d = is_lo;
`else
      set = is_hi;
      clr = is_lo;
`endif
      mc2 = mc1;
      mc1 = set ? 1'b1 : (clr ? 1'b0 : mc1);
    end
    #1;
  endtask

  function automatic logic [10:0] tone_sample(input int t, input int half);
    if (((t / half) % 2) == 0) return 11'(MID + int'($urandom_range(1023, HYST)));
    return 11'(MID - int'($urandom_range(1024, HYST)));
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom), 11'($urandom));
      n_checks++;
      if (obs !== 8'h00) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%b required=%b", i, obs, 8'h00);
      end
    end
  endtask

  task automatic test_tone(input int half, input logic exp_code, input string name);
    for (int t = 0; t < SYM_LEN; t++) begin
      step(1'b0, 1'b1, tone_sample(t, half));
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s t=%0d got=%b required=%b", name, t, obs, exp_v);
      end
    end
    n_checks++;
    if ({code_valid, code_out, code_weak, code_out_b} !== {1'b1, exp_code, 1'b0, ~exp_code}) begin
      n_fail++;
      $display("FAIL %s_decision got v/c/w/cb=%b required=%b", name,
               {code_valid, code_out, code_weak, code_out_b}, {1'b1, exp_code, 1'b0, ~exp_code});
    end
  endtask

  task automatic test_boundary();
    logic [10:0] d;
`ifdef FSK_DEGLITCH_EN
    int last_lo = SYM_LEN - 4;
`else
    int last_lo = SYM_LEN - 3;
`endif
    for (int t = 0; t < SYM_LEN; t++) begin
      if (t > last_lo) d = tone_sample(0, 1);
      else if (t < 23 * 64 && (t % 64) < 32) d = tone_sample(0, 1);
      else d = tone_sample(1, 1);
      step(1'b0, 1'b1, d);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL boundary t=%0d got=%b required=%b", t, obs, exp_v);
      end
    end
    n_checks++;
    if ({code_valid, code_out, code_weak} !== 3'b111) begin
      n_fail++;
      $display("FAIL boundary_decision got v/c/w=%b required=111", {code_valid, code_out, code_weak});
    end
  endtask

  task automatic test_hyst();
    int   rise_t = -1;
    logic prev = clk1;
    for (int t = 0; t < SYM_LEN; t++) begin
      step(1'b0, 1'b1, (t % 2 == 0) ? 11'd1034 : 11'd1014);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL hyst t=%0d got=%b required=%b", t, obs, exp_v);
      end
      if (clk1 && !prev && rise_t < 0) rise_t = t;
      prev = clk1;
    end
    n_checks++;
    if ({rise_t, code_valid, code_out, code_weak} !== {32'd1024, 3'b100}) begin
      n_fail++;
      $display("FAIL hyst_clk1 got rise=%0d v/c/w=%b required rise=1024 v/c/w=100",
               rise_t, {code_valid, code_out, code_weak});
    end
  endtask

  task automatic test_freeze();
    logic held;
    for (int t = 0; t < 1800; t++) begin
      step(1'b0, (t < 1300 || t >= 1600), tone_sample(t, 32));
      if (t == 1299) held = clk1;
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL freeze t=%0d got=%b required=%b", t, obs, exp_v);
      end
      if (t >= 1300 && t < 1600) begin
        n_checks++;
        if ({clk1, code_valid} !== {held, 1'b0}) begin
          n_fail++;
          $display("FAIL freeze_hold t=%0d got clk1/v=%b required=%b", t, {clk1, code_valid}, {held, 1'b0});
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, tone_sample(i, 1));
      n_checks++;
      if (obs !== 8'h00) begin
        n_fail++;
        $display("FAIL freeze_rst cyc=%0d got=%b required=%b", i, obs, 8'h00);
      end
    end
    test_tone(64, 1'b0, "after_rst");
  endtask

  task automatic test_en_end();
    int guard = 0;
    while (mpos != SYM_LEN - 1 && guard < SYM_LEN) begin
      step(1'b0, 1'b1, tone_sample(guard, 32));
      guard++;
    end
    n_checks++;
    if (mpos != SYM_LEN - 1) begin
      n_fail++;
      $display("FAIL en_end_reach got pos=%0d required=%0d", mpos, SYM_LEN - 1);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, tone_sample(i, 1));
      n_checks++;
      if (obs !== exp_v || code_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL en_end_off i=%0d got=%b required=%b", i, obs, exp_v);
      end
    end
    step(1'b0, 1'b1, tone_sample(0, 1));
    n_checks++;
    if ({code_valid, code_out} !== 2'b11 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL en_end_strobe got=%b required=%b", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    int          half = 40;
    logic [10:0] d;
    for (int t = 0; t < 3 * SYM_LEN; t++) begin
      if ($urandom_range(63, 0) == 0) d = ($urandom % 2 == 0) ? 11'd2047 : 11'd0;
      else d = tone_sample(t, half);
      step(1'b0, ($urandom_range(15, 0) != 0), d);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random t=%0d half=%0d got=%b required=%b", t, half, obs, exp_v);
      end
      if (m_valid) half = int'($urandom_range(64, 16));
    end
  endtask

  initial begin
    test_reset();
    test_tone(64, 1'b0, "tone128");
    test_tone(32, 1'b1, "tone64");
    test_boundary();
    test_hyst();
    test_freeze();
    test_en_end();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
